kernel_kcore_start_fanout_fifo: RTL and testbench

KERNEL_KCORE_START_FANOUT_FIFO -- requirements
Module: kernel_kcore_start_fanout_fifo

---
 rtl/kernel_kcore_start_fanout_fifo.sv | 106 ++++++++++
 tb/tb_kernel_kcore_start_fanout_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kernel_kcore_start_fanout_fifo.sv
// Broadcast FIFO: one producer write is copied into NUM_CH independent
// shift-register channels. Each channel has its own read port and occupancy.
module kernel_kcore_start_fanout_fifo #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 2,
  parameter int DEPTH        = 4,
  parameter int NUM_CH       = 2,
  parameter int AFULL_THRESH = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             if_write,
  input  logic                             if_write_ce,
  input  logic [DATA_WIDTH-1:0]            if_din,
  output logic                             if_full_n,
  output logic                             if_almost_full,
  input  logic [NUM_CH-1:0]                if_read,
  input  logic [NUM_CH-1:0]                if_read_ce,
  output logic [NUM_CH-1:0]                if_empty_n,
  output logic [NUM_CH*DATA_WIDTH-1:0]     if_dout,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] if_count
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [CW-1:0]     cnt_r     [NUM_CH];
  logic [CW-1:0]     cnt_nxt_s [NUM_CH];
  logic              wr_acc_s;
  logic [NUM_CH-1:0] rd_acc_s;
  logic              full_n_r;
  logic              full_n_nxt_s;
  logic              afull_r;
  logic              afull_nxt_s;
  logic [NUM_CH-1:0] empty_n_r;
  logic [NUM_CH-1:0] empty_n_nxt_s;

  assign wr_acc_s       = if_write & if_write_ce & full_n_r;
  assign rd_acc_s       = if_read & if_read_ce & empty_n_r;
  assign if_full_n      = full_n_r;
  assign if_almost_full = afull_r;
  assign if_empty_n     = empty_n_r;

  // Next occupancy per channel and the flags derived from it
  always_comb begin
    full_n_nxt_s  = 1'b1;
    afull_nxt_s   = 1'b0;
    empty_n_nxt_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_nxt_s[k] = cnt_r[k];
      case ({wr_acc_s, rd_acc_s[k]})
        2'b10:   cnt_nxt_s[k] = cnt_r[k] + CW'(1);
        2'b01:   cnt_nxt_s[k] = cnt_r[k] - CW'(1);
        default: cnt_nxt_s[k] = cnt_r[k];
      endcase
      empty_n_nxt_s[k] = (cnt_nxt_s[k] != {CW{1'b0}});
      full_n_nxt_s     = full_n_nxt_s & (cnt_nxt_s[k] < CW'(DEPTH));
      afull_nxt_s      = afull_nxt_s | (cnt_nxt_s[k] >= CW'(AFULL_THRESH));
    end
  end

  // Occupancy counters and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_r[k] <= {CW{1'b0}};
      end
      empty_n_r <= {NUM_CH{1'b0}};
      full_n_r  <= 1'b1;
      afull_r   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
      end
      empty_n_r <= empty_n_nxt_s;
      full_n_r  <= full_n_nxt_s;
      afull_r   <= afull_nxt_s;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] store_r [DEPTH];
    logic [DATA_WIDTH-1:0] sel_s;

    // Newest token enters at index 0; store contents are deliberately not reset
    always_ff @(posedge clk) begin
      if (wr_acc_s && !reset) begin
        store_r[0] <= if_din;
        for (int i = 1; i < DEPTH; i++) begin
          store_r[i] <= store_r[i-1];
        end
      end
    end

    // Oldest token sits at index cnt-1
    always_comb begin
      sel_s = store_r[0];
      for (int i = 0; i < DEPTH; i++) begin
        sel_s = (cnt_r[k] == CW'(i + 1)) ? store_r[i] : sel_s;
      end
    end

    assign if_dout[k*DATA_WIDTH +: DATA_WIDTH] = sel_s;
    assign if_count[k*CW +: CW]                = cnt_r[k];
  end

endmodule

// File: tb/tb_kernel_kcore_start_fanout_fifo.sv
// Directed bench for kernel_kcore_start_fanout_fifo: default two-channel
// instance plus a three-channel byte-wide instance.
module tb_kernel_kcore_start_fanout_fifo;

  logic       clk;
  logic       reset;
  logic       write;
  logic       write_ce;
  logic       din;
  logic       full_n;
  logic       almost_full;
  logic [1:0] read;
  logic [1:0] read_ce;
  logic [1:0] empty_n;
  logic [1:0] dout;
  logic [5:0] count;

  logic        b_write;
  logic        b_write_ce;
  logic [7:0]  b_din;
  logic        b_full_n;
  logic        b_almost_full;
  logic [2:0]  b_read;
  logic [2:0]  b_read_ce;
  logic [2:0]  b_empty_n;
  logic [23:0] b_dout;
  logic [8:0]  b_count;

  int compared;
  int mismatched;

  kernel_kcore_start_fanout_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .if_write       (write),
    .if_write_ce    (write_ce),
    .if_din         (din),
    .if_full_n      (full_n),
    .if_almost_full (almost_full),
    .if_read        (read),
    .if_read_ce     (read_ce),
    .if_empty_n     (empty_n),
    .if_dout        (dout),
    .if_count       (count)
  );

  kernel_kcore_start_fanout_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .DEPTH      (3),
    .NUM_CH     (3)
  ) dut_b (
    .clk            (clk),
    .reset          (reset),
    .if_write       (b_write),
    .if_write_ce    (b_write_ce),
    .if_din         (b_din),
    .if_full_n      (b_full_n),
    .if_almost_full (b_almost_full),
    .if_read        (b_read),
    .if_read_ce     (b_read_ce),
    .if_empty_n     (b_empty_n),
    .if_dout        (b_dout),
    .if_count       (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1; write = 1'b0; write_ce = 1'b0; din = 1'b0;
    read = 2'b00; read_ce = 2'b00;
    b_write = 1'b0; b_write_ce = 1'b0; b_din = 8'h00;
    b_read = 3'b000; b_read_ce = 3'b000;
    step();
    step();
    reset = 1'b0;
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty_n", 32'(empty_n), 32'h0);
    check("rst_full_n", 32'(full_n), 32'h1);
    check("rst_afull", 32'(almost_full), 32'h0);

    // three-channel instance: broadcast of 0xA5
    b_write = 1'b1; b_write_ce = 1'b1; b_din = 8'hA5;
    step();
    b_write = 1'b0;
    check("b_dout", 32'(b_dout), 32'hA5A5A5);
    check("b_count", 32'(b_count), 32'(9'b001_001_001));
    check("b_empty_n", 32'(b_empty_n), 32'h7);

    // fill with 1,0,1,1; ce low blocks the write
    write = 1'b1; write_ce = 1'b0; din = 1'b0;
    step();
    check("ce_block_count", 32'(count), 32'h0);
    write_ce = 1'b1; din = 1'b1;
    step();
    check("w1_count", 32'(count), 32'(6'b001_001));
    check("w1_empty_n", 32'(empty_n), 32'h3);
    check("w1_dout", 32'(dout), 32'h3);
    din = 1'b0;
    step();
    check("w2_afull", 32'(almost_full), 32'h0);
    din = 1'b1;
    step();
    check("w3_afull", 32'(almost_full), 32'h1);
    check("w3_full_n", 32'(full_n), 32'h1);
    din = 1'b1;
    step();
    check("w4_full_n", 32'(full_n), 32'h0);
    check("w4_count", 32'(count), 32'(6'b100_100));

    // full: read ch0 with concurrent write, write must be ignored
    din = 1'b0; read = 2'b01; read_ce = 2'b11;
    step();
    write = 1'b0;
    check("fullrd_count", 32'(count), 32'(6'b100_011));
    check("fullrd_full_n", 32'(full_n), 32'h0);
    check("fullrd_dout", 32'(dout), 32'h2);

    // drain ch0: remaining 1,1
    step();
    check("ch0_dout_a", 32'(dout[0]), 32'h1);
    step();
    check("ch0_dout_b", 32'(dout[0]), 32'h1);
    step();
    check("ch0_empty", 32'(empty_n), 32'h2);

    // drain ch1 (1,0,1,1) while also reading empty ch0
    read = 2'b11;
    check("ch1_dout_0", 32'(dout[1]), 32'h1);
    step();
    check("ch1_full_n", 32'(full_n), 32'h1);
    check("ch1_dout_1", 32'(dout[1]), 32'h0);
    check("ch0_underflow_count", 32'(count[2:0]), 32'h0);
    step();
    check("ch1_dout_2", 32'(dout[1]), 32'h1);
    step();
    check("ch1_dout_3", 32'(dout[1]), 32'h1);
    step();
    check("drained_empty_n", 32'(empty_n), 32'h0);
    check("drained_count", 32'(count), 32'h0);
    read = 2'b00;

    // cnt=2/2 (tokens 1 then 0), then write 1 with read on ch0
    write = 1'b1; din = 1'b1;
    step();
    din = 1'b0;
    step();
    check("two_count", 32'(count), 32'(6'b010_010));
    din = 1'b1; read = 2'b01;
    step();
    write = 1'b0; read = 2'b00;
    check("wr_rd_count", 32'(count), 32'(6'b011_010));
    check("wr_rd_dout", 32'(dout), 32'h2);
    check("wr_rd_afull", 32'(almost_full), 32'h1);

    // reach 3/1, then reset with write and reads pending
    read = 2'b10;
    step();
    step();
    write = 1'b1; din = 1'b0; read = 2'b10;
    step();
    check("pre_rst_count", 32'(count), 32'(6'b001_011));
    reset = 1'b1; read = 2'b11;
    step();
    reset = 1'b0; write = 1'b0; read = 2'b00;
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_empty_n", 32'(empty_n), 32'h0);
    check("mid_rst_full_n", 32'(full_n), 32'h1);
    check("mid_rst_afull", 32'(almost_full), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
